ysyx_22040237_ifu: RTL

Instruction fetch unit, directly upstream of the decode stage. Holds the architectural fetch PC and issues one instruction-memory request at a time, allowing one outstanding request. It buffers the returned word with its PC in a single-entry output register and presents that pair to decode through a valid/ready handshake. Branch/jump redirects from execute flush the buffer and discard any in-flight response.

---
 rtl/ysyx_22040237_ifu.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22040237_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_ifu -- instruction fetch unit
//
// Holds the fetch PC and issues one instruction-memory request at a time,
// with at most one request outstanding. The returned word and its PC go
// into a single-entry output buffer. That buffer is offered to decode
// through a valid/ready handshake. A redirect from execute has several
// effects:
//   - it flushes the buffer;
//   - it discards any response that is still in flight;
//   - it restarts fetch at the target address, aligned down to 4 bytes.
//
// Ports
//   clk, rst_n                 core clock, asynchronous active-low reset
//   imem_req_valid_o/ready_i   fetch request handshake
//   imem_req_addr_o            fetch address (always 4-byte aligned)
//   imem_rsp_valid_i           response word valid
//   imem_rsp_data_i            instruction word
//   imem_rsp_err_i             access fault for this response
//   redirect_valid_i/pc_i      one-cycle redirect pulse and its target
//   halt_i                     level; blocks new requests only
//   inst_valid_o/ready_i       decode-side handshake
//   inst_o, pc_o, inst_fault_o buffered instruction, its PC, fault flag
// ---------------------------------------------------------------------------
module ysyx_22040237_ifu #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [63:0] imem_req_addr_o,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   input  logic        imem_rsp_err_i,
   input  logic        redirect_valid_i,
   input  logic [63:0] redirect_pc_i,
   input  logic        halt_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [63:0] pc_o,
   output logic        inst_fault_o
);

   typedef enum logic {
      S_REQ  = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

   state_t      r_state;
   logic [63:0] r_pc;          // next fetch PC
   logic [63:0] r_req_pc;      // PC of the outstanding request
   logic        r_kill;        // outstanding response must be discarded
   logic        r_buf_valid;
   logic [31:0] r_inst;
   logic [63:0] r_pc_out;
   logic        r_fault;

   logic w_pop;
   logic w_req_fire;
   logic w_rsp;
   logic w_load;

   assign w_pop = r_buf_valid & inst_ready_i;

   // A request may go out only when the buffer can take the answer.
   // "Can take" means the buffer is empty, or it drains this cycle.
   // The rst_n term holds the request low while reset is asserted.
   assign imem_req_valid_o = rst_n & (r_state == S_REQ) & ~halt_i
                           & ~redirect_valid_i & (~r_buf_valid | w_pop);
   assign imem_req_addr_o  = r_pc;

   assign w_req_fire = imem_req_valid_o & imem_req_ready_i;
   // A response counts only in WAIT. In REQ there is nothing outstanding.
   assign w_rsp      = (r_state == S_WAIT) & imem_rsp_valid_i;
   assign w_load     = w_rsp & ~r_kill & ~redirect_valid_i;

   assign inst_valid_o = r_buf_valid;
   assign inst_o       = r_inst;
   assign pc_o         = r_pc_out;
   assign inst_fault_o = r_fault;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_REQ;
         r_pc        <= RESET_PC;
         r_req_pc    <= 64'd0;
         r_kill      <= 1'b0;
         r_buf_valid <= 1'b0;
         r_inst      <= 32'd0;
         r_pc_out    <= 64'd0;
         r_fault     <= 1'b0;
      end else begin
         // A redirect wins over the sequential PC increment.
         if (redirect_valid_i)
            r_pc <= {redirect_pc_i[63:2], 2'b00};
         else if (w_req_fire)
            r_pc <= r_pc + 64'd4;

         if (w_req_fire)
            r_req_pc <= r_req_pc_next(r_pc);

         unique case (r_state)
            S_REQ: begin
               if (w_req_fire)
                  r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (w_rsp) begin
                  // The response is consumed either way. Any pending kill
                  // has now done its job.
                  r_state <= S_REQ;
                  r_kill  <= 1'b0;
               end else if (redirect_valid_i) begin
                  r_kill  <= 1'b1;
               end
            end
         endcase

         // The flush beats both a refill and a pop in the same cycle.
         if (redirect_valid_i) begin
            r_buf_valid <= 1'b0;
         end else if (w_load) begin
            r_buf_valid <= 1'b1;
            r_inst      <= imem_rsp_err_i ? NOP_INST : imem_rsp_data_i;
            r_pc_out    <= r_req_pc;
            r_fault     <= imem_rsp_err_i;
         end else if (w_pop) begin
            r_buf_valid <= 1'b0;
         end
      end
   end

   function automatic logic [63:0] r_req_pc_next(input logic [63:0] pc);
      return pc;
   endfunction

endmodule
